// File: rtl/fifo_4x8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_4x8_pkg
//  Description : Shared constants and types for the 8-entry, 4-bit FIFO.
//                DATA_W : data word width (4)
//                DEPTH  : number of storage entries (8, power of two)
//                PTR_W  : read/write pointer width (log2(DEPTH) = 3)
//                CNT_W  : occupancy counter width (must hold 0..DEPTH)
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_4x8_pkg;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  // One extra bit so the counter can represent DEPTH itself (the full state).
  localparam int CNT_W  = PTR_W + 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t C_CNT_FULL  = cnt_t'(DEPTH);
  localparam cnt_t C_CNT_EMPTY = '0;

  // Pointer advance. DEPTH is a power of two, so the natural wrap of the
  // PTR_W-bit addition gives modulo-DEPTH behaviour (7 -> 0).
  function automatic ptr_t ptr_next(input ptr_t p);
    return p + 1'b1;
  endfunction

endpackage : fifo_4x8_pkg
`default_nettype wire

// File: rtl/fifo_4x8_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_4x8_mem
//  Description : DEPTH x DATA_W register array backing the FIFO.
//                Synchronous write port, asynchronous (combinational) read.
//                Contents are not reset; the owning FIFO never reads an
//                entry it has not written since its own reset.
//  Ports       : clk      - rising-edge clock
//                we_i     - write enable
//                waddr_i  - write address
//                wdata_i  - write data
//                raddr_i  - read address
//                rdata_o  - read data (combinational from raddr_i)
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_4x8_mem
  import fifo_4x8_pkg::*;
(
  input  logic  clk,
  input  logic  we_i,
  input  ptr_t  waddr_i,
  input  data_t wdata_i,
  input  ptr_t  raddr_i,
  output data_t rdata_o
);

  data_t mem_q [DEPTH];

  // One register per entry, each with its own decoded write strobe.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic w_sel;
    assign w_sel = we_i && (waddr_i == ptr_t'(gi));

    always_ff @(posedge clk) begin
      if (w_sel) begin
        mem_q[gi] <= wdata_i;
      end
    end
  end : g_entry

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_4x8_mem
`default_nettype wire

// File: rtl/fifo_4x8.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_4x8
//  Description : Synchronous single-clock FIFO, 4-bit data, 8 entries.
//                Level-sensitive write/read enables, one operation of each
//                per clock. Registered read data with one-cycle latency, no
//                fall-through. full/empty decode directly from the
//                registered occupancy count, so they have no combinational
//                path from the enables.
//  Ports       : clk      - rising-edge clock
//                reset    - asynchronous active-low reset
//                wData    - write data
//                wEnable  - write request (level)
//                rEnable  - read request (level)
//                rData    - registered read data (holds when no read)
//                full     - FIFO holds DEPTH words
//                empty    - FIFO holds zero words
//  Option      : FIFO_ERR_FLAGS_EN adds sticky outputs
//                overflow  - set by any ignored write (write while full,
//                            no simultaneous read)
//                underflow - set by any ignored read (read while empty)
//                Both cleared only by reset.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_4x8
  import fifo_4x8_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  data_t wData,
  input  logic  wEnable,
  input  logic  rEnable,
  output data_t rData,
  output logic  full,
  output logic  empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic  overflow,
  output logic  underflow
`endif
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q,  count_d;
  data_t rdata_q,  rdata_d;

  logic  w_wr_acc;
  logic  w_rd_acc;
  logic  w_full;
  logic  w_empty;
  data_t w_mem_rdata;

  assign w_full  = (count_q == C_CNT_FULL);
  assign w_empty = (count_q == C_CNT_EMPTY);

  // A read frees a slot in the same edge, so a write while full is still
  // accepted when paired with a read. The read side never depends on the
  // write side, which keeps the decision loop-free and forbids fall-through.
  assign w_rd_acc = rEnable && !w_empty;
  assign w_wr_acc = wEnable && (!w_full || w_rd_acc);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  fifo_4x8_mem u_mem (
    .clk     (clk),
    .we_i    (w_wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wData),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;

    if (w_wr_acc) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end

    if (w_rd_acc) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
      rdata_d  = w_mem_rdata;
    end

    // Simultaneous accept (or neither) leaves occupancy unchanged.
    case ({w_wr_acc, w_rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rData = rdata_q;
  assign full  = w_full;
  assign empty = w_empty;

  // --------------------------------------------------------------------------
  // Optional sticky error flags
  // --------------------------------------------------------------------------
`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (wEnable && !w_wr_acc) begin
      ovf_d = 1'b1;
    end
    if (rEnable && !w_rd_acc) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule : fifo_4x8
`default_nettype wire

// File: tb/tb_fifo_4x8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_4x8
//  Description : Self-checking bench for fifo_4x8. Directed sequence
//                (reset, fill, overflow, drain, underflow, wrap, full
//                read+write, mid-stream reset) followed by randomized
//                traffic, all compared against a queue-based model.
//                Honours FIFO_ERR_FLAGS_EN for the sticky error outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_4x8;

  logic       clk;
  logic       reset;
  logic [3:0] wData;
  logic       wEnable;
  logic       rEnable;
  logic [3:0] rData;
  logic       full;
  logic       empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  fifo_4x8 dut (
    .clk     (clk),
    .reset   (reset),
    .wData   (wData),
    .wEnable (wEnable),
    .rEnable (rEnable),
    .rData   (rData),
    .full    (full),
    .empty   (empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, last read word, sticky flags.
  logic [3:0] mq[$];
  logic [3:0] m_rdata;
  logic       m_ovf;
  logic       m_unf;

  int n_total;
  int n_bad;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".rData"}, 32'(rData), 32'(m_rdata));
    check_val({tag, ".full"},  32'(full),  32'(mq.size() == 8));
    check_val({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
    check_val({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check_val({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, check just after.
  task automatic step(input logic we, input logic re, input logic [3:0] wd,
                      input string tag);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    wEnable = we;
    rEnable = re;
    wData   = wd;
    @(posedge clk);
    rd_ok = re && (mq.size() > 0);
    wr_ok = we && ((mq.size() < 8) || rd_ok);
    if (we && !wr_ok) m_ovf = 1'b1;
    if (re && !rd_ok) m_unf = 1'b1;
    if (rd_ok) m_rdata = mq.pop_front();
    if (wr_ok) mq.push_back(wd);
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata = 4'h0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    wData   = 4'h0;
    wEnable = 1'b0;
    rEnable = 1'b0;
    reset   = 1'b1;
    model_reset();

    // Reset asserted asynchronously, held across a few edges.
    #2 reset = 1'b0;
    #1 check_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1 check_outputs("reset_held");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, "idle");

    // Fill 0..7.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i), "fill");
    // Overflow attempts 8..15 while full.
    for (int i = 8; i < 16; i++) step(1'b1, 1'b0, 4'(i), "overflow");
    // Drain: expect 0..7.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h0, "drain");
    // Underflow: rData must hold 7.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h0, "underflow");
    // Write while empty with read: write accepted, no fall-through.
    step(1'b1, 1'b1, 4'hA, "empty_rw");
    step(1'b0, 1'b1, 4'h0, "empty_rw_rd");

    // Wrap: write 5, read 3, write 6 -> full with pointers wrapped.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'(i + 3), "wrap_w5");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h0, "wrap_r3");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'(15 - i), "wrap_w6");
    // Full with simultaneous read and write.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'(i + 1), "full_rw");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h0, "wrap_drain");

    // Mid-stream reset: contents discarded immediately.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(9 + i), "pre_rst");
    step(1'b1, 1'b1, 4'h6, "pre_rst_rw");
    #2 reset = 1'b0;
    model_reset();
    #1 check_outputs("reset_mid");
    @(negedge clk);
    reset   = 1'b1;
    wEnable = 1'b0;
    rEnable = 1'b0;
    step(1'b0, 1'b1, 4'h0, "post_rst_rd");
    step(1'b1, 1'b0, 4'h5, "post_rst_wr");
    step(1'b0, 1'b1, 4'h0, "post_rst_rd2");

    // Randomized traffic in phases biased toward filling and draining.
    for (int ph = 0; ph < 8; ph++) begin
      int wp;
      int rp;
      wp = (ph % 2 == 0) ? 80 : 25;
      rp = (ph % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 50; i++) begin
        step(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp),
             4'($urandom_range(0, 15)), "random");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule : tb_fifo_4x8
`default_nettype wire
